// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, FSM state
// encoding and the packed control word driven toward the ALU/accumulator.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_OUT = 4'h4;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_OPERAND = 3'd2,
        S_EXEC    = 3'd3,
        S_OUTPUT  = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    typedef struct packed {
        logic ein;   // input byte onto bus
        logic li;    // load instruction register
        logic n_la;  // active-low accumulator load
        logic lb;    // load B register
        logic ea;    // accumulator onto bus
        logic eu;    // ALU result onto bus
        logic sub;   // ALU subtract select
        logic lo;    // load output register
    } ctrl_t;

    // Quiescent control word: every strobe inactive, n_la held high.
    localparam ctrl_t CTRL_IDLE = '{ein: 1'b0, li: 1'b0, n_la: 1'b1, lb: 1'b0,
                                    ea: 1'b0, eu: 1'b0, sub: 1'b0, lo: 1'b0};

    // Opcodes that take an operand byte in the OPERAND state.
    function automatic logic op_has_operand(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/sap_ctrl_decode.sv
// Combinational control-word decode: state, IR opcode and instr_valid in,
// bus enables and load strobes out.
module sap_ctrl_decode
    import sap_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       instr_valid,
    output ctrl_t      ctrl
);

    // Moore decode per state; only FETCH/OPERAND strobes are qualified by instr_valid
    always_comb begin
        ctrl = CTRL_IDLE;
        unique case (state)
            S_FETCH: begin
                ctrl.ein = 1'b1;
                ctrl.li  = instr_valid;
            end
            S_OPERAND: begin
                ctrl.ein = 1'b1;
                if (opcode == OP_LDA) begin
                    ctrl.n_la = ~instr_valid;
                end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    ctrl.lb = instr_valid;
                end
            end
            S_EXEC: begin
                ctrl.eu   = 1'b1;
                ctrl.n_la = 1'b0;
                ctrl.sub  = (opcode == OP_SUB);
            end
            S_OUTPUT: begin
                ctrl.ea = 1'b1;
                ctrl.lo = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP fetch/decode/execute sequencer: holds state, IR, flag latches and the
// instruction handshake; control word comes from sap_ctrl_decode.
// Build option: define SEQ_ILLEGAL_TRAP_EN to halt (illegal=1) on undefined
// opcodes; otherwise undefined opcodes behave as NOP.
module sap_control_sequencer
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic       cf,
    input  logic       zf,
    output logic       ein,
    output logic       li,
    output logic       n_la,
    output logic       lb,
    output logic       ea,
    output logic       eu,
    output logic       sub,
    output logic       lo,
    output logic       cf_q,
    output logic       zf_q,
    output logic       halted,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       cf_d, zf_d;
    logic       halted_q, halted_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic       illegal_q, illegal_d;
`endif

    logic [3:0] opcode;
    logic       accept_window;
    ctrl_t      dec_ctrl;
    ctrl_t      ctrl;
    logic       unused_ir_low;

    assign opcode        = ir_q[7:4];
    assign unused_ir_low = ^ir_q[3:0];
    assign accept_window = (state_q == S_FETCH) || (state_q == S_OPERAND);

    sap_ctrl_decode u_decode (
        .state       (state_q),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .ctrl        (dec_ctrl)
    );

    // Reset forces the idle word immediately, even though FETCH would assert ein
    assign ctrl        = rst ? CTRL_IDLE : dec_ctrl;
    assign instr_ready = ~rst & accept_window;

    assign ein  = ctrl.ein;
    assign li   = ctrl.li;
    assign n_la = ctrl.n_la;
    assign lb   = ctrl.lb;
    assign ea   = ctrl.ea;
    assign eu   = ctrl.eu;
    assign sub  = ctrl.sub;
    assign lo   = ctrl.lo;

    assign halted = halted_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Next-state, IR capture and flag capture
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        unique case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_NOP) begin
                    state_d = S_FETCH;
                end else if (op_has_operand(opcode)) begin
                    state_d = S_OPERAND;
                end else if (opcode == OP_OUT) begin
                    state_d = S_OUTPUT;
                end else if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_OPERAND: begin
                if (instr_valid) begin
                    state_d = (opcode == OP_LDA) ? S_FETCH : S_EXEC;
                end
            end
            S_EXEC: begin
                cf_d    = cf;
                zf_d    = zf;
                state_d = S_FETCH;
            end
            S_OUTPUT: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        halted_d = (state_d == S_HALT);
    end

    // All sequencer state, asynchronously cleared by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            cf_q      <= 1'b0;
            zf_q      <= 1'b0;
            halted_q  <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cf_q      <= cf_d;
            zf_q      <= zf_d;
            halted_q  <= halted_d;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed self-checking bench for sap_control_sequencer with a small
// accumulator/B/ALU/output-register model wired to the control lines.
module tb_sap_control_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic       cf, zf;
    logic       ein, li, n_la, lb, ea, eu, sub, lo;
    logic       cf_q, zf_q, halted, illegal;

    logic [7:0] acc_m = 8'h00;
    logic [7:0] b_m   = 8'h00;
    logic [7:0] out_m = 8'h00;
    logic [8:0] alu;
    logic [7:0] bus;
    int         nla_lows = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    sap_control_sequencer dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .cf(cf), .zf(zf),
        .ein(ein), .li(li), .n_la(n_la), .lb(lb), .ea(ea), .eu(eu),
        .sub(sub), .lo(lo), .cf_q(cf_q), .zf_q(zf_q),
        .halted(halted), .illegal(illegal)
    );

    // Datapath model: subtract as A + ~B + 1, carry out of bit 8
    always_comb begin
        alu = sub ? ({1'b0, acc_m} + {1'b0, ~b_m} + 9'd1)
                  : ({1'b0, acc_m} + {1'b0, b_m});
        if (ein)     bus = instr;
        else if (ea) bus = acc_m;
        else if (eu) bus = alu[7:0];
        else         bus = 8'h00;
    end
    assign cf = alu[8];
    assign zf = (alu[7:0] == 8'h00);

    always @(posedge clk) begin
        if (!n_la) begin
            acc_m    <= bus;
            nla_lows <= nla_lows + 1;
        end
        if (lb) b_m   <= bus;
        if (lo) out_m <= bus;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, then move to the sampling point
    task automatic step(input logic [7:0] b, input logic v);
        instr       = b;
        instr_valid = v;
        @(negedge clk);
        check("one_bus_driver", 8'(int'(ein) + int'(ea) + int'(eu) <= 1), 8'd1);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_lda(input logic [7:0] v);
        step(8'h10, 1'b1); adv();
        step(8'h00, 1'b0); adv();
        step(v, 1'b1);     adv();
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_ready", 8'(instr_ready), 8'd0);
        check("rst_ein",   8'(ein),         8'd0);
        check("rst_n_la",  8'(n_la),        8'd1);
        check("rst_halt",  8'(halted),      8'd0);
        check("rst_ill",   8'(illegal),     8'd0);
        check("rst_flags", {6'd0, cf_q, zf_q}, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LDA 0x25: one n_la pulse, in the operand handshake cycle, 3 cycles total
        step(8'h10, 1'b1);
        check("lda_f_ready", 8'(instr_ready), 8'd1);
        check("lda_f_li",    8'(li),          8'd1);
        check("lda_f_ein",   8'(ein),         8'd1);
        check("lda_f_nla",   8'(n_la),        8'd1);
        adv();
        step(8'h00, 1'b0);
        check("lda_d_ready", 8'(instr_ready), 8'd0);
        check("lda_d_ein",   8'(ein),         8'd0);
        check("lda_d_nla",   8'(n_la),        8'd1);
        adv();
        step(8'h25, 1'b1);
        check("lda_o_nla",   8'(n_la),        8'd0);
        check("lda_o_lb",    8'(lb),          8'd0);
        check("lda_o_ein",   8'(ein),         8'd1);
        adv();
        step(8'h00, 1'b0);
        check("lda_back_ready", 8'(instr_ready), 8'd1);
        check("lda_acc",        acc_m,           8'h25);
        check("lda_pulses",     8'(nla_lows),    8'd1);
        adv();

        // LDA 0xF0 then ADD 0x20 issued back-to-back: 0x110 -> A=0x10, cf=1, zf=0
        do_lda(8'hF0);
        step(8'h20, 1'b1);
        check("b2b_ready", 8'(instr_ready), 8'd1);
        adv();
        step(8'h00, 1'b0); adv();
        step(8'h20, 1'b1);
        check("add_o_lb",  8'(lb),   8'd1);
        check("add_o_nla", 8'(n_la), 8'd1);
        adv();
        step(8'h00, 1'b0);
        check("add_x_eu",  8'(eu),   8'd1);
        check("add_x_nla", 8'(n_la), 8'd0);
        check("add_x_sub", 8'(sub),  8'd0);
        adv();
        step(8'h00, 1'b0);
        check("add_ready", 8'(instr_ready), 8'd1);
        check("add_acc",   acc_m,           8'h10);
        check("add_cf",    8'(cf_q),        8'd1);
        check("add_zf",    8'(zf_q),        8'd0);
        adv();

        // LDA 0x05, SUB 0x05 -> zero, no borrow
        do_lda(8'h05);
        step(8'h30, 1'b1); adv();
        step(8'h00, 1'b0); adv();
        step(8'h05, 1'b1); adv();
        step(8'h00, 1'b0);
        check("sub_x_sub", 8'(sub), 8'd1);
        check("sub_x_eu",  8'(eu),  8'd1);
        adv();
        step(8'h00, 1'b0);
        check("sub_acc", acc_m,    8'h00);
        check("sub_zf",  8'(zf_q), 8'd1);
        check("sub_cf",  8'(cf_q), 8'd1);
        adv();

        // NOP: back in FETCH after 2 cycles, flags hold
        step(8'h00, 1'b1); adv();
        step(8'h00, 1'b0);
        check("nop_d_ready", 8'(instr_ready), 8'd0);
        adv();
        step(8'h00, 1'b0);
        check("nop_ready", 8'(instr_ready), 8'd1);
        check("nop_zf",    8'(zf_q),        8'd1);
        adv();

        // LDA 0x5A, then OUT: ea/lo for one cycle, flags still held
        do_lda(8'h5A);
        step(8'h40, 1'b1); adv();
        step(8'h00, 1'b0); adv();
        step(8'h00, 1'b0);
        check("out_ea",  8'(ea),  8'd1);
        check("out_lo",  8'(lo),  8'd1);
        check("out_ein", 8'(ein), 8'd0);
        adv();
        step(8'h00, 1'b0);
        check("out_lo_off", 8'(lo),          8'd0);
        check("out_ready",  8'(instr_ready), 8'd1);
        check("out_reg",    out_m,           8'h5A);
        check("out_zf",     8'(zf_q),        8'd1);
        check("out_cf",     8'(cf_q),        8'd1);
        adv();

        // ADD with 5 stall cycles in OPERAND: 0x5A + 0xA6 = 0x100
        step(8'h20, 1'b1); adv();
        step(8'h00, 1'b0); adv();
        for (int i = 0; i < 5; i++) begin
            step(8'h33, 1'b0);
            check("stall_lb",    8'(lb),          8'd0);
            check("stall_ready", 8'(instr_ready), 8'd1);
            adv();
        end
        step(8'hA6, 1'b1);
        check("stall_op_lb", 8'(lb), 8'd1);
        adv();
        step(8'h00, 1'b0);
        check("stall_x_eu", 8'(eu), 8'd1);
        adv();
        step(8'h00, 1'b0);
        check("stall_acc", acc_m,    8'h00);
        check("stall_cf",  8'(cf_q), 8'd1);
        check("stall_zf",  8'(zf_q), 8'd1);
        adv();

        // Undefined opcode 0x7
        step(8'h70, 1'b1); adv();
        step(8'h00, 1'b0); adv();
`ifdef SEQ_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            step(8'h10, 1'b1);
            check("ill_halted", 8'(halted),      8'd1);
            check("ill_flag",   8'(illegal),     8'd1);
            check("ill_ready",  8'(instr_ready), 8'd0);
            check("ill_li",     8'(li),          8'd0);
            adv();
        end
`else
        step(8'h00, 1'b0);
        check("ill_nop_ready",  8'(instr_ready), 8'd1);
        check("ill_nop_halted", 8'(halted),      8'd0);
        check("ill_nop_flag",   8'(illegal),     8'd0);
        adv();
`endif
        rst = 1'b1;
        #1;
        check("rst1_halted", 8'(halted),      8'd0);
        check("rst1_ill",    8'(illegal),     8'd0);
        check("rst1_ready",  8'(instr_ready), 8'd0);
        check("rst1_flags",  {6'd0, cf_q, zf_q}, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // HLT: stuck until rst, nothing accepted
        step(8'hF0, 1'b1); adv();
        step(8'h00, 1'b0); adv();
        for (int i = 0; i < 3; i++) begin
            step(8'h20, 1'b1);
            check("hlt_halted", 8'(halted),      8'd1);
            check("hlt_ready",  8'(instr_ready), 8'd0);
            check("hlt_ein",    8'(ein),         8'd0);
            check("hlt_li",     8'(li),          8'd0);
            check("hlt_nla",    8'(n_la),        8'd1);
            check("hlt_ill",    8'(illegal),     8'd0);
            adv();
        end
        rst = 1'b1;
        #1;
        check("rst2_halted", 8'(halted), 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ADD 0x07 interrupted by rst in EXEC: A must stay 0x00
        step(8'h20, 1'b1); adv();
        step(8'h00, 1'b0); adv();
        step(8'h07, 1'b1); adv();
        rst = 1'b1;
        #1;
        check("rst3_nla",   8'(n_la),        8'd1);
        check("rst3_eu",    8'(eu),          8'd0);
        check("rst3_ready", 8'(instr_ready), 8'd0);
        check("rst3_ein",   8'(ein),         8'd0);
        @(posedge clk); #1;
        check("rst3_acc",    acc_m,              8'h00);
        check("rst3_flags",  {6'd0, cf_q, zf_q}, 8'd0);
        check("rst3_halted", 8'(halted),         8'd0);
        rst = 1'b0;
        step(8'h00, 1'b0);
        check("post_rst_ready", 8'(instr_ready), 8'd1);
        check("post_rst_ein",   8'(ein),         8'd1);
        check("post_rst_li",    8'(li),          8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
